// File: rtl/i2s_pkg.sv
// Shared definitions for the PCM5102 I2S transmitter: slot geometry helpers and FSM encoding.
package i2s_pkg;

  localparam int SLOT_WIDTH_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int frame_bits(input int slot_width);
    return 2 * slot_width;
  endfunction

  function automatic int bit_cnt_w(input int slot_width);
    return $clog2(2 * slot_width);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// BCK divider and frame bit counter; produces the registered bit clock and the fall strobe.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int BCK_DIV    = 83,
  parameter int SLOT_WIDTH = SLOT_WIDTH_DEF,
  localparam int CNT_W     = bit_cnt_w(SLOT_WIDTH)
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             enable,
  output logic             i2s_bck,
  output logic             fall_stb,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int DIV_W = $clog2(BCK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [DIV_W-1:0] RISE_AT  = DIV_W'(BCK_DIV / 2);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(frame_bits(SLOT_WIDTH) - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             rise_stb;

  assign fall_stb = enable && (div_cnt == '0);
  assign rise_stb = enable && (div_cnt == RISE_AT);

  // Losing enable restarts everything from bit 0 with BCK low.
  always_ff @(posedge clk) begin
    if (!resetb || !enable) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      i2s_bck <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (fall_stb) begin
        i2s_bck <= 1'b0;
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end else if (rise_stb) begin
        i2s_bck <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_pcm5102.sv
// Stereo I2S serialiser for the PCM5102: lock-gated FSM, one-deep sample holding register
// and per-channel shift registers driven from the BCK fall strobe.
module i2s_tx_pcm5102
  import i2s_pkg::*;
#(
  parameter int BCK_DIV      = 83,
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = SLOT_WIDTH_DEF
) (
  input  logic                    clock_in,
  input  logic                    resetb,
  input  logic                    pll_locked,
  input  logic [SAMPLE_WIDTH-1:0] sample_left,
  input  logic [SAMPLE_WIDTH-1:0] sample_right,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    i2s_bck,
  output logic                    i2s_lrck,
  output logic                    i2s_data,
  output logic                    underrun
);

  localparam int CNT_W = bit_cnt_w(SLOT_WIDTH);
  localparam logic [CNT_W-1:0] LEFT_LAST   = CNT_W'(SAMPLE_WIDTH);
  localparam logic [CNT_W-1:0] SLOT_START  = CNT_W'(SLOT_WIDTH);
  localparam logic [CNT_W-1:0] RIGHT_FIRST = CNT_W'(SLOT_WIDTH + 1);
  localparam logic [CNT_W-1:0] RIGHT_LAST  = CNT_W'(SLOT_WIDTH + SAMPLE_WIDTH);

  state_t state, state_next;
  logic   run_ok;
  logic   fall_stb;
  logic   [CNT_W-1:0] bit_cnt;

  logic                    hold_full, hold_full_nxt;
  logic [SAMPLE_WIDTH-1:0] hold_left, hold_right;
  logic [SAMPLE_WIDTH-1:0] left_sr, right_sr;
  logic                    accept, frame_load, ready_nxt;

  i2s_clkgen #(
    .BCK_DIV   (BCK_DIV),
    .SLOT_WIDTH(SLOT_WIDTH)
  ) u_clkgen (
    .clk     (clock_in),
    .resetb  (resetb),
    .enable  (run_ok),
    .i2s_bck (i2s_bck),
    .fall_stb(fall_stb),
    .bit_cnt (bit_cnt)
  );

  always_ff @(posedge clock_in) begin
    if (!resetb) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    run_ok     = 1'b0;
    unique case (state)
      IDLE: if (pll_locked) state_next = RUN;
      RUN: begin
        if (!pll_locked) state_next = IDLE;
        run_ok = pll_locked;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept     = sample_valid && sample_ready;
  assign frame_load = fall_stb && (bit_cnt == '0);

  // A load in the same cycle as an accept sees the old (empty) register; the new pair survives.
  always_comb begin
    hold_full_nxt = hold_full;
    if (!resetb || !run_ok)  hold_full_nxt = 1'b0;
    else if (accept)         hold_full_nxt = 1'b1;
    else if (frame_load)     hold_full_nxt = 1'b0;
    ready_nxt = resetb && (state_next == RUN) && !hold_full_nxt;
  end

  always_ff @(posedge clock_in) begin
    underrun     <= 1'b0;
    hold_full    <= hold_full_nxt;
    sample_ready <= ready_nxt;
    if (!resetb || !run_ok) begin
      hold_left  <= '0;
      hold_right <= '0;
      left_sr    <= '0;
      right_sr   <= '0;
      i2s_lrck   <= 1'b0;
      i2s_data   <= 1'b0;
    end else begin
      if (accept) begin
        hold_left  <= sample_left;
        hold_right <= sample_right;
      end
      // Outputs use the pre-advance bit_cnt, so LRCK flips one BCK ahead of each MSB.
      if (fall_stb) begin
        i2s_lrck <= (bit_cnt >= SLOT_START);
        i2s_data <= 1'b0;
        if (frame_load) begin
          left_sr  <= hold_full ? hold_left  : '0;
          right_sr <= hold_full ? hold_right : '0;
          underrun <= !hold_full;
        end else if (bit_cnt <= LEFT_LAST) begin
          i2s_data <= left_sr[SAMPLE_WIDTH-1];
          left_sr  <= {left_sr[SAMPLE_WIDTH-2:0], 1'b0};
        end else if (bit_cnt >= RIGHT_FIRST && bit_cnt <= RIGHT_LAST) begin
          i2s_data <= right_sr[SAMPLE_WIDTH-1];
          right_sr <= {right_sr[SAMPLE_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_pcm5102.sv
// Directed bench for i2s_tx_pcm5102 at BCK_DIV=4: frame contents, handshake, underrun,
// simultaneous accept/load, lock loss and reset mid-frame.
`timescale 1ns/1ps
module tb_i2s_tx_pcm5102;

  logic        clock_in = 1'b0;
  logic        resetb;
  logic        pll_locked;
  logic [23:0] sample_left;
  logic [23:0] sample_right;
  logic        sample_valid;
  logic        sample_ready;
  logic        i2s_bck;
  logic        i2s_lrck;
  logic        i2s_data;
  logic        underrun;

  int checks = 0;
  int errors = 0;
  logic accept_pend = 1'b0;
  logic stream_on = 1'b0;

  i2s_tx_pcm5102 #(
    .BCK_DIV     (4),
    .SAMPLE_WIDTH(24),
    .SLOT_WIDTH  (32)
  ) dut (
    .clock_in    (clock_in),
    .resetb      (resetb),
    .pll_locked  (pll_locked),
    .sample_left (sample_left),
    .sample_right(sample_right),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .i2s_bck     (i2s_bck),
    .i2s_lrck    (i2s_lrck),
    .i2s_data    (i2s_data),
    .underrun    (underrun)
  );

  always #5 clock_in = ~clock_in;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Upstream model: after an accept it either offers the next incrementing pair or withdraws.
  task automatic step();
    @(negedge clock_in);
    if (accept_pend) begin
      if (stream_on) begin
        sample_left++;
        sample_right++;
      end else begin
        sample_valid = 1'b0;
      end
    end
    accept_pend = sample_valid && sample_ready;
  endtask

  task automatic apply_stimulus(input logic v, input logic [23:0] l, input logic [23:0] r);
    sample_valid = v;
    sample_left  = l;
    sample_right = r;
    accept_pend  = v && sample_ready;
  endtask

  function automatic logic [4:0] out_vec();
    return {i2s_bck, i2s_lrck, i2s_data, underrun, sample_ready};
  endfunction

  // Called on the cycle just before a frame's bit-0 fall strobe; consumes the whole frame.
  task automatic check_frame(input string tag, input logic [23:0] exp_l, input logic [23:0] exp_r,
                             input logic exp_under, input logic exp_ready);
    logic [63:0] data_bits, lrck_bits;
    logic d1, l1;
    int bck_bad = 0, unstable = 0, under_bad = 0;
    d1 = 1'b0;
    l1 = 1'b0;
    for (int k = 0; k < 64; k++) begin
      for (int p = 1; p <= 4; p++) begin
        step();
        if (p == 1) begin
          d1 = i2s_data;
          l1 = i2s_lrck;
          data_bits[63-k] = i2s_data;
          lrck_bits[63-k] = i2s_lrck;
        end else if (i2s_data !== d1 || i2s_lrck !== l1) begin
          unstable++;
        end
        if (i2s_bck !== (p >= 3)) bck_bad++;
        if (k == 0 && p == 1) begin
          check_output({tag, " underrun"}, underrun, exp_under);
          check_output({tag, " ready"}, sample_ready, exp_ready);
        end else if (underrun !== 1'b0) begin
          under_bad++;
        end
      end
    end
    check_output({tag, " data"}, data_bits, {1'b0, exp_l, 7'b0, 1'b0, exp_r, 7'b0});
    check_output({tag, " lrck"}, lrck_bits, {32'h0, 32'hFFFF_FFFF});
    check_output({tag, " bck"}, bck_bad, 0);
    check_output({tag, " stable"}, unstable, 0);
    check_output({tag, " underrun_extra"}, under_bad, 0);
  endtask

  initial begin
    int bad;
    resetb       = 1'b0;
    pll_locked   = 1'b0;
    sample_valid = 1'b0;
    sample_left  = '0;
    sample_right = '0;
    repeat (3) step();
    check_output("reset outputs", out_vec(), 5'b0);

    // Unlocked with valid asserted: nothing may move.
    resetb = 1'b1;
    apply_stimulus(1'b1, 24'hABCDEF, 24'h123456);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (out_vec() !== 5'b0) bad++;
    end
    check_output("unlocked idle", bad, 0);

    pll_locked = 1'b1;
    step();
    check_output("lock entry ready", sample_ready, 1'b1);
    check_output("lock entry bck", i2s_bck, 1'b0);
    // Pending pair is accepted on the very first frame load: muted frame, then data.
    check_frame("f0 sim", 24'h0, 24'h0, 1'b1, 1'b0);
    check_frame("f1 data", 24'hABCDEF, 24'h123456, 1'b0, 1'b1);
    check_frame("f2 underrun", 24'h0, 24'h0, 1'b1, 1'b1);
    check_frame("f3 underrun", 24'h0, 24'h0, 1'b1, 1'b1);

    stream_on = 1'b1;
    apply_stimulus(1'b1, 24'hC0FFE0, 24'h3C3C3C);
    check_frame("f4 sim", 24'h0, 24'h0, 1'b1, 1'b0);
    check_frame("f5 stream", 24'hC0FFE0, 24'h3C3C3C, 1'b0, 1'b1);
    check_frame("f6 stream", 24'hC0FFE1, 24'h3C3C3D, 1'b0, 1'b1);
    check_frame("f7 stream", 24'hC0FFE2, 24'h3C3C3E, 1'b0, 1'b1);
    stream_on = 1'b0;

    // Frame carrying 0xC0FFE3; holding register takes 0xC0FFE4 then lock drops at bit_cnt 10.
    for (int c = 1; c <= 39; c++) begin
      step();
      if (c == 1) begin
        check_output("f8 underrun", underrun, 1'b0);
        check_output("f8 ready", sample_ready, 1'b1);
      end
      if (c == 2) check_output("f8 captured", sample_ready, 1'b0);
    end
    check_output("pre-loss outputs", {i2s_bck, i2s_lrck, i2s_data}, 3'b101);
    pll_locked = 1'b0;
    step();
    check_output("lock loss outputs", out_vec(), 5'b0);
    bad = 0;
    repeat (5) begin
      step();
      if (out_vec() !== 5'b0) bad++;
    end
    check_output("lock loss hold", bad, 0);
    pll_locked = 1'b1;
    step();
    check_output("relock ready", sample_ready, 1'b1);
    check_frame("relock empty", 24'h0, 24'h0, 1'b1, 1'b1);

    apply_stimulus(1'b1, 24'h00C001, 24'hFFFFFE);
    check_frame("fa sim", 24'h0, 24'h0, 1'b1, 1'b0);
    for (int c = 1; c <= 39; c++) begin
      step();
      if (c == 4) apply_stimulus(1'b1, 24'h111111, 24'h222222);
    end
    check_output("pre-reset outputs", out_vec(), 5'b10100);
    resetb = 1'b0;
    step();
    check_output("mid reset outputs", out_vec(), 5'b0);
    resetb = 1'b1;
    step();
    check_output("post reset ready", sample_ready, 1'b1);
    check_frame("post reset empty", 24'h0, 24'h0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
